pipe_hazard_ctrl: RTL and testbench

Pipeline sequencing controller that drives the enable/clear controls of the PC, IF/ID and ID/EX pipeline registers. It detects load-use hazards, squashes wrong-path fetches after a taken branch resolves in EX, and freezes the front end while a multi-cycle mul/div occupies EX. It also inserts a decode bubble on instruction-fetch stalls and keeps a saturating stall-cycle performance counter.

---
 rtl/pipe_hazard_ctrl.sv | 138 +++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller: PC / IF/ID / ID/EX enables and clears.
// Handles load-use bubbles, branch flushes, mul/div freeze, fetch stalls.
module pipe_hazard_ctrl #(
  parameter int REG_W       = 5,
  parameter int FLUSH_DEPTH = 2,
  parameter int MD_LAT      = 4,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] rs_d,
  input  logic [REG_W-1:0] rt_d,
  input  logic             uses_rt_d,
  input  logic [REG_W-1:0] rd_e,
  input  logic             memread_e,
  input  logic             branch_taken_e,
  input  logic             md_start_e,
  input  logic             icache_stall,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             if_id_clr,
  output logic             id_ex_en,
  output logic             id_ex_clr,
  output logic             md_busy,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int MAXC =
    (FLUSH_DEPTH > MD_LAT) ? FLUSH_DEPTH : MD_LAT;
  localparam int CW = $clog2(MAXC) + 1;
  localparam logic [CW-1:0] FD_RL = CW'(FLUSH_DEPTH - 1);
  localparam logic [CW-1:0] MD_RL = CW'(MD_LAT - 1);
  localparam logic [CW-1:0] ONE   = CW'(1);

  typedef enum logic [1:0] {
    RUN,
    FLUSH,
    MD_BUSY
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          load_use;

  assign load_use = memread_e && (rd_e != '0) &&
    ((rs_d == rd_e) || (uses_rt_d && (rt_d == rd_e)));

  // State and remaining-cycle counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // Next state and same-cycle pipeline controls
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    pc_en     = 1'b1;
    if_id_en  = 1'b1;
    if_id_clr = 1'b0;
    id_ex_en  = 1'b1;
    id_ex_clr = 1'b0;
    md_busy   = 1'b0;
    if (!reset) begin
      unique case (state)
        RUN: begin
          if (branch_taken_e) begin
            if_id_clr = 1'b1;
            id_ex_clr = 1'b1;
            if (FLUSH_DEPTH > 1) begin
              state_n = FLUSH;
              cnt_n   = FD_RL;
            end
          end else if (md_start_e) begin
            pc_en    = 1'b0;
            if_id_en = 1'b0;
            id_ex_en = 1'b0;
            if (MD_LAT > 1) begin
              state_n = MD_BUSY;
              cnt_n   = MD_RL;
            end
          end else if (load_use) begin
            pc_en     = 1'b0;
            if_id_en  = 1'b0;
            id_ex_clr = 1'b1;
          end else if (icache_stall) begin
            pc_en     = 1'b0;
            if_id_clr = 1'b1;
          end
        end
        FLUSH: begin
          if_id_clr = 1'b1;
          pc_en     = !icache_stall;
          if (branch_taken_e) begin
            id_ex_clr = 1'b1;
            cnt_n     = FD_RL;
          end else if (cnt == ONE) begin
            state_n = RUN;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt - ONE;
          end
        end
        MD_BUSY: begin
          pc_en    = 1'b0;
          if_id_en = 1'b0;
          id_ex_en = 1'b0;
          md_busy  = 1'b1;
          if (cnt == ONE) begin
            state_n = RUN;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt - ONE;
          end
        end
        default: begin
          state_n = RUN;
          cnt_n   = '0;
        end
      endcase
    end
  end

  // Saturating count of cycles with the PC frozen
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (!pc_en && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl.
// Directed steps then random traffic against a cycle-budget model.
module tb_pipe_hazard_ctrl;

  localparam int RW  = 5;
  localparam int FD  = 2;
  localparam int ML  = 4;
  localparam int CNW = 4;
  localparam int SAT = (1 << CNW) - 1;

  logic           clk = 1'b0;
  logic           reset;
  logic [RW-1:0]  rs_d, rt_d, rd_e;
  logic           uses_rt_d, memread_e;
  logic           branch_taken_e, md_start_e, icache_stall;
  logic           pc_en, if_id_en, if_id_clr;
  logic           id_ex_en, id_ex_clr, md_busy;
  logic [CNW-1:0] stall_cnt;

  int total = 0;
  int bad   = 0;

  // model: remaining flush / mul-div cycles and stall count
  int m_flush = 0;
  int m_md    = 0;
  int m_stall = 0;
  logic [5:0] m_out;

  pipe_hazard_ctrl #(
    .REG_W(RW), .FLUSH_DEPTH(FD), .MD_LAT(ML), .CNT_W(CNW)
  ) dut (
    .clk(clk), .reset(reset),
    .rs_d(rs_d), .rt_d(rt_d), .uses_rt_d(uses_rt_d),
    .rd_e(rd_e), .memread_e(memread_e),
    .branch_taken_e(branch_taken_e),
    .md_start_e(md_start_e),
    .icache_stall(icache_stall),
    .pc_en(pc_en), .if_id_en(if_id_en),
    .if_id_clr(if_id_clr), .id_ex_en(id_ex_en),
    .id_ex_clr(id_ex_clr), .md_busy(md_busy),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [31:0] obs,
                     logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // outputs packed {pc,ifen,ifclr,exen,exclr,busy}
  function automatic logic [5:0] model_out(
    output int nf, output int nm);
    logic lu;
    logic [5:0] o;
    nf = m_flush;
    nm = m_md;
    o  = 6'b110100;
    lu = memread_e && rd_e != 0 &&
      (rs_d == rd_e || (uses_rt_d && rt_d == rd_e));
    if (reset) begin
      nf = 0;
      nm = 0;
    end else if (m_md > 0) begin
      o  = 6'b000001;
      nm = m_md - 1;
    end else if (m_flush > 0) begin
      o  = {!icache_stall, 5'b11100};
      if (branch_taken_e) begin
        o[1] = 1'b1;
        nf   = FD - 1;
      end else begin
        nf = m_flush - 1;
      end
    end else if (branch_taken_e) begin
      o  = 6'b111110;
      nf = FD - 1;
    end else if (md_start_e) begin
      o  = 6'b000000;
      nm = ML - 1;
    end else if (lu) begin
      o = 6'b000110;
    end else if (icache_stall) begin
      o = 6'b011100;
    end
    return o;
  endfunction

  task automatic step(string tag, bit br, bit md, bit mr,
                      int rd, int rs, int rt, bit urt, bit ic);
    int nf, nm;
    logic [5:0] got;
    branch_taken_e = br;
    md_start_e     = md;
    memread_e      = mr;
    rd_e           = RW'(rd);
    rs_d           = RW'(rs);
    rt_d           = RW'(rt);
    uses_rt_d      = urt;
    icache_stall   = ic;
    #1;
    if (reset) m_stall = 0;
    m_out = model_out(nf, nm);
    got = {pc_en, if_id_en, if_id_clr,
           id_ex_en, id_ex_clr, md_busy};
    chk({tag, ".ctl"}, 32'(got), 32'(m_out));
    chk({tag, ".cnt0"}, 32'(stall_cnt), 32'(m_stall));
    @(posedge clk);
    m_flush = nf;
    m_md    = nm;
    if (reset) m_stall = 0;
    else if (!m_out[5] && m_stall < SAT) m_stall++;
    #1;
    chk({tag, ".cnt1"}, 32'(stall_cnt), 32'(m_stall));
  endtask

  task automatic idle(string tag);
    step(tag, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    reset = 1'b1;
    idle("rst_a");
    step("rst_busy_in", 1, 1, 1, 5, 5, 5, 1, 1);
    chk("rst_pc", 32'(pc_en), 32'd1);
    chk("rst_md_busy", 32'(md_busy), 32'd0);
    reset = 1'b0;
    idle("run_idle");

    step("lu_rs", 0, 0, 1, 5, 5, 0, 0, 0);
    chk("lu_stall1", 32'(stall_cnt), 32'd1);
    idle("lu_after");
    step("r0", 0, 0, 1, 0, 0, 0, 1, 0);
    step("rt_unused", 0, 0, 1, 7, 1, 7, 0, 0);
    step("rt_used", 0, 0, 1, 7, 1, 7, 1, 0);

    step("br0", 1, 0, 0, 0, 0, 0, 0, 0);
    idle("br1");
    idle("br2");

    step("md0", 0, 1, 0, 0, 0, 0, 0, 0);
    idle("md1");
    step("md2_br", 1, 0, 0, 0, 0, 0, 0, 0);
    idle("md3");
    idle("md_done");

    step("prio3", 1, 1, 1, 3, 3, 0, 0, 0);
    chk("prio_flush", 32'(if_id_clr), 32'd1);
    step("prio_fl_ic", 0, 0, 0, 0, 0, 0, 0, 1);
    step("lu_ic", 0, 0, 1, 4, 0, 4, 1, 1);
    chk("lu_ic_hold", 32'({if_id_en, if_id_clr}), 32'd0);
    step("ic_only", 0, 0, 0, 0, 0, 0, 0, 1);

    step("md_r0", 0, 1, 0, 0, 0, 0, 0, 0);
    idle("md_r1");
    reset = 1'b1;
    idle("md_rst");
    chk("mdrst_cnt", 32'(stall_cnt), 32'd0);
    reset = 1'b0;
    idle("post_rst");

    step("br_r0", 1, 0, 0, 0, 0, 0, 0, 0);
    reset = 1'b1;
    idle("fl_rst");
    reset = 1'b0;
    idle("post_rst2");

    for (int i = 0; i < 20; i++)
      step("sat", 0, 0, 0, 0, 0, 0, 0, 1);
    chk("sat_hold", 32'(stall_cnt), 32'(SAT));

    reset = 1'b1;
    idle("rnd_rst");
    reset = 1'b0;
    for (int i = 0; i < 400; i++) begin
      reset = ($urandom_range(99) < 2);
      step("rnd",
        $urandom_range(99) < 12,
        $urandom_range(99) < 6,
        $urandom_range(99) < 40,
        int'($urandom_range(3)),
        int'($urandom_range(3)),
        int'($urandom_range(3)),
        $urandom_range(1) == 1,
        $urandom_range(99) < 25);
    end
    reset = 1'b0;
    idle("end");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
